multicycle_decoder: RTL and testbench
=====================================

MULTICYCLE_DECODER -- requirements
Module: multicycle_decoder

Interface
REQ-001 Parameter ALU_CTRL_W, default 3: width of ALUControl; legal range 3..5.
REQ-002 Parameter MEM_WAIT_EN, default 1: 1 = FETCH/MEMRD/MEMWR wait on MemReady; 0 = MemReady ignored, treated as 1.
REQ-003 clk  input  1  rising-edge clock; the block has one clock.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 Op  input  2  instruction class: 00 data-processing, 01 memory, 10 branch.
REQ-006 Funct  input  6  instruction bits [25:20].
REQ-007 Rd  input  4  destination register.
REQ-008 CondEx  input  1  condition check passed for current instruction.
REQ-009 MemReady  input  1  memory access completes this cycle.
REQ-010 IRWrite, AdrSrc, ALUSrcA, PCWrite, RegWrite, MemWrite  output  1 each  datapath strobes/selects.
REQ-011 ResultSrc, ALUSrcB, ImmSrc, RegSrc, FlagW  output  2 each  datapath selects; FlagW[1]=NZ, FlagW[0]=CV.
REQ-012 ALUControl  output  ALU_CTRL_W  ALU operation.
REQ-013 NoWrite, Link  output  1 each  CMP suppression; BL link write.
REQ-014 State  output  4  current FSM state, debug only.

Function
REQ-015 States SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, plus MULEX when MUL_EN is defined.
REQ-016 Transitions:
- FETCH->DECODE on MemReady, else stay.
- DECODE by Op: 00 -> EXECI if Funct[5], else EXECR; 01 -> MEMADR; 10 -> BRANCH; 11 -> FETCH.
- MEMADR -> MEMRD if Funct[0], else MEMWR.
- MEMRD -> MEMWB on MemReady, else stay.
- MEMWR -> FETCH on MemReady, else stay.
- EXECR/EXECI -> ALUWB.
- MEMWB, ALUWB, BRANCH -> FETCH.
REQ-017 FETCH SHALL assert AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10 and ALUControl=ADD; IRWrite and PCWrite SHALL be asserted only in the cycle MemReady=1.
REQ-018 DECODE SHALL drive ALUSrcA=1, ALUSrcB=10, ResultSrc=10 with no write strobes.
REQ-019 MEMADR SHALL drive ALUSrcA=0, ALUSrcB=01, ALUControl=ADD, ImmSrc=01; Funct[3]=0 selects SUB.
REQ-020 MEMRD/MEMWR SHALL drive AdrSrc=1; MemWrite=CondEx&MemReady in MEMWR only.
REQ-021 MEMWB SHALL drive ResultSrc=01 and RegWrite=CondEx.
REQ-022 In EXECR/EXECI, ALUControl SHALL decode Funct[4:1]: 0100 ADD=0, 0010 SUB=1, 0000 AND=2, 1100 ORR=3, 1010 CMP=SUB, 1101 MOV=6, 0001 EOR=7, other=0; values are zero-extended to ALU_CTRL_W.
REQ-023 EXECI SHALL drive ALUSrcB=01 and ImmSrc=00; EXECR SHALL drive ALUSrcB=00 and RegSrc=00.
REQ-024 FlagW SHALL be 00 outside EXECR/EXECI/MULEX; inside them FlagW[1]=Funct[0] and FlagW[0]=Funct[0]&(ADD|SUB|CMP), each gated by CondEx.
REQ-025 ALUWB SHALL drive ResultSrc=00 and RegWrite=CondEx&~NoWrite; NoWrite=1 iff the instruction is DP with Funct[4:1]=1010.
REQ-026 In ALUWB, Rd=1111 with RegWrite SHALL also assert PCWrite.
REQ-027 BRANCH SHALL drive ALUSrcA=0, ALUSrcB=01, ImmSrc=10, ResultSrc=10 and PCWrite=CondEx.
REQ-028 In BRANCH, Link=Funct[4] and RegWrite=CondEx&Funct[4] (BL writes LR).
REQ-029 Op=11 SHALL produce no write strobes and return to FETCH after DECODE.
REQ-030 All strobes SHALL be Moore outputs of State, gated only by CondEx/MemReady as stated; unlisted outputs default to 0.

Reset
REQ-031 Asserting reset SHALL force FETCH immediately, independent of clk, and all strobes SHALL read 0 while reset is held.
REQ-032 Reset mid-MEMWR SHALL deassert MemWrite without waiting for MemReady.
REQ-033 The first FETCH after reset release SHALL begin on the next rising edge.

Configuration
REQ-034 Macro MUL_EN: when defined, DECODE routes Op=00, Funct[5:4]=00 with Funct[3:1]=000 (MUL encoding) to MULEX, which drives ALUControl=4 and ALUSrcB=00, then ALUWB.
REQ-035 When MUL_EN is not defined, MULEX SHALL not exist and the MUL encoding SHALL decode as AND.

Verification
REQ-036 ADD R1,R2,#5 with MemReady=1 and CondEx=1 -> FETCH,DECODE,EXECI,ALUWB; RegWrite=1 in ALUWB; FlagW=00.
REQ-037 LDR with MemReady low for 3 cycles in MEMRD -> state held 3 cycles; MEMWB RegWrite=1 with ResultSrc=01.
REQ-038 CMP with S=1 -> NoWrite=1, FlagW=11 in EXECR, RegWrite=0 in ALUWB.
REQ-039 BL with CondEx=1 -> BRANCH asserts PCWrite=1, Link=1, RegWrite=1; with CondEx=0 all three are 0.
REQ-040 reset asserted during MEMWR with MemReady=0 -> MemWrite drops the same cycle; State=FETCH.
REQ-041 MUL_EN defined, MUL issued -> MULEX with ALUControl=4; undefined -> EXECR with ALUControl=2.

Source files
------------

// File: rtl/multicycle_decoder_if.sv
// Control bundle between the ARM-style instruction fields and the datapath strobes.
// Latency: none (wiring only).
// Backpressure: none of its own; MemReady is the only stall input and it travels here.
interface multicycle_decoder_if #(
  parameter int ALU_CTRL_W = 3
);
  // Instruction fields and memory status, supplied by the datapath
  logic [1:0]            Op;
  logic [5:0]            Funct;
  logic [3:0]            Rd;
  logic                  CondEx;
  logic                  MemReady;

  // Datapath strobes and selects, produced by the decoder
  logic                  IRWrite;
  logic                  AdrSrc;
  logic                  ALUSrcA;
  logic                  PCWrite;
  logic                  RegWrite;
  logic                  MemWrite;
  logic [1:0]            ResultSrc;
  logic [1:0]            ALUSrcB;
  logic [1:0]            ImmSrc;
  logic [1:0]            RegSrc;
  logic [1:0]            FlagW;
  logic [ALU_CTRL_W-1:0] ALUControl;
  logic                  NoWrite;
  logic                  Link;
  logic [3:0]            State;

  // Datapath side: drives instruction fields, consumes the control outputs
  modport master (
    output Op, Funct, Rd, CondEx, MemReady,
    input  IRWrite, AdrSrc, ALUSrcA, PCWrite, RegWrite, MemWrite,
    input  ResultSrc, ALUSrcB, ImmSrc, RegSrc, FlagW, ALUControl,
    input  NoWrite, Link, State
  );

  // Decoder side
  modport slave (
    input  Op, Funct, Rd, CondEx, MemReady,
    output IRWrite, AdrSrc, ALUSrcA, PCWrite, RegWrite, MemWrite,
    output ResultSrc, ALUSrcB, ImmSrc, RegSrc, FlagW, ALUControl,
    output NoWrite, Link, State
  );
endinterface

// File: rtl/multicycle_decoder.sv
// Multicycle ARM-subset control unit: FSM sequencing plus per-state datapath strobes.
// Latency: one state per clock; FETCH/MEMRD/MEMWR stall on MemReady (when MEM_WAIT_EN=1).
// Backpressure: MemReady low holds the FSM; all outputs are Moore decodes of State.
// Optional feature: define MUL_EN to add the MULEX state for the MUL encoding.
// ALU_CTRL_W is legal from 3 to 5; ALU codes are zero-extended into it.
module multicycle_decoder #(
  parameter int ALU_CTRL_W  = 3,
  parameter int MEM_WAIT_EN = 1
) (
  input logic                 clk,
  input logic                 reset,
  multicycle_decoder_if.slave bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
`ifdef MUL_EN
    , S_MULEX = 4'd10
`endif
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_ORR = 3'd3;
  localparam logic [2:0] ALU_MOV = 3'd6;
  localparam logic [2:0] ALU_EOR = 3'd7;
`ifdef MUL_EN
  localparam logic [2:0] ALU_MUL = 3'd4;
`endif

  state_t     r_state;
  state_t     w_next;

  logic       w_mem_ready;
  logic       w_is_dp;
  logic       w_is_cmp;
  logic [2:0] w_dp_alu;
  logic       w_dp_arith;
`ifdef MUL_EN
  logic       w_is_mul;
`endif

  // Combinational outputs before they reach the interface
  logic       w_ir;
  logic       w_adr;
  logic       w_srca;
  logic       w_pcw;
  logic       w_rw;
  logic       w_mw;
  logic [1:0] w_res;
  logic [1:0] w_srcb;
  logic [1:0] w_imm;
  logic [1:0] w_regsrc;
  logic [1:0] w_flagw;
  logic [2:0] w_alu;
  logic       w_nowr;
  logic       w_link;

  // With waiting disabled the memory is treated as always ready
  assign w_mem_ready = (MEM_WAIT_EN != 0) ? bus.MemReady : 1'b1;

  assign w_is_dp  = (bus.Op == 2'b00);
  // CMP is the only data-processing command that must not write its result
  assign w_is_cmp = w_is_dp && (bus.Funct[4:1] == 4'b1010);
`ifdef MUL_EN
  assign w_is_mul = w_is_dp && (bus.Funct[5:1] == 5'b00000);
`endif

  // Data-processing command decode; w_dp_arith marks commands that update C/V
  always_comb begin
    w_dp_alu   = ALU_ADD;
    w_dp_arith = 1'b0;
    case (bus.Funct[4:1])
      4'b0100: begin w_dp_alu = ALU_ADD; w_dp_arith = 1'b1; end
      4'b0010: begin w_dp_alu = ALU_SUB; w_dp_arith = 1'b1; end
      4'b1010: begin w_dp_alu = ALU_SUB; w_dp_arith = 1'b1; end
      4'b0000: w_dp_alu = ALU_AND;
      4'b1100: w_dp_alu = ALU_ORR;
      4'b1101: w_dp_alu = ALU_MOV;
      4'b0001: w_dp_alu = ALU_EOR;
      default: w_dp_alu = ALU_ADD;
    endcase
  end

  // State register; reset forces FETCH immediately, independent of the clock
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (w_mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (bus.Op)
          2'b00: begin
`ifdef MUL_EN
            if (w_is_mul)          w_next = S_MULEX;
            else if (bus.Funct[5]) w_next = S_EXECI;
            else                   w_next = S_EXECR;
`else
            if (bus.Funct[5]) w_next = S_EXECI;
            else              w_next = S_EXECR;
`endif
          end
          2'b01:   w_next = S_MEMADR;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_next = bus.Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (w_mem_ready) w_next = S_MEMWB;
      S_MEMWR:  if (w_mem_ready) w_next = S_FETCH;
      S_EXECR:  w_next = S_ALUWB;
      S_EXECI:  w_next = S_ALUWB;
`ifdef MUL_EN
      S_MULEX:  w_next = S_ALUWB;
`endif
      S_MEMWB:  w_next = S_FETCH;
      S_ALUWB:  w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      default:  w_next = S_FETCH;
    endcase
  end

  // Per-state outputs; everything stays at zero while reset is held so that a
  // reset arriving mid-access drops MemWrite without a clock edge
  always_comb begin
    w_ir     = 1'b0;
    w_adr    = 1'b0;
    w_srca   = 1'b0;
    w_pcw    = 1'b0;
    w_rw     = 1'b0;
    w_mw     = 1'b0;
    w_res    = 2'b00;
    w_srcb   = 2'b00;
    w_imm    = 2'b00;
    w_regsrc = 2'b00;
    w_flagw  = 2'b00;
    w_alu    = ALU_ADD;
    w_nowr   = 1'b0;
    w_link   = 1'b0;
    if (reset) begin
      w_nowr = w_is_cmp;
      case (r_state)
        S_FETCH: begin
          w_srca = 1'b1;
          w_srcb = 2'b10;
          w_res  = 2'b10;
          w_ir   = w_mem_ready;
          w_pcw  = w_mem_ready;
        end
        S_DECODE: begin
          w_srca = 1'b1;
          w_srcb = 2'b10;
          w_res  = 2'b10;
        end
        S_MEMADR: begin
          w_srcb = 2'b01;
          w_imm  = 2'b01;
          // U bit clear means the offset is subtracted
          w_alu  = bus.Funct[3] ? ALU_ADD : ALU_SUB;
        end
        S_MEMRD: begin
          w_adr = 1'b1;
        end
        S_MEMWR: begin
          w_adr = 1'b1;
          w_mw  = bus.CondEx & w_mem_ready;
        end
        S_MEMWB: begin
          w_res = 2'b01;
          w_rw  = bus.CondEx;
        end
        S_EXECR: begin
          w_srcb   = 2'b00;
          w_regsrc = 2'b00;
          w_alu    = w_dp_alu;
          w_flagw  = {bus.Funct[0] & bus.CondEx,
                      bus.Funct[0] & w_dp_arith & bus.CondEx};
        end
        S_EXECI: begin
          w_srcb  = 2'b01;
          w_imm   = 2'b00;
          w_alu   = w_dp_alu;
          w_flagw = {bus.Funct[0] & bus.CondEx,
                     bus.Funct[0] & w_dp_arith & bus.CondEx};
        end
`ifdef MUL_EN
        S_MULEX: begin
          w_srcb  = 2'b00;
          w_alu   = ALU_MUL;
          // MUL only ever updates N/Z
          w_flagw = {bus.Funct[0] & bus.CondEx, 1'b0};
        end
`endif
        S_ALUWB: begin
          w_res = 2'b00;
          w_rw  = bus.CondEx & ~w_is_cmp;
          // A write to R15 is a jump
          w_pcw = bus.CondEx & ~w_is_cmp & (bus.Rd == 4'b1111);
        end
        S_BRANCH: begin
          w_srcb = 2'b01;
          w_imm  = 2'b10;
          w_res  = 2'b10;
          w_pcw  = bus.CondEx;
          w_link = bus.CondEx & bus.Funct[4];
          w_rw   = bus.CondEx & bus.Funct[4];
        end
        default: begin
          w_res = 2'b00;
        end
      endcase
    end
  end

  assign bus.IRWrite    = w_ir;
  assign bus.AdrSrc     = w_adr;
  assign bus.ALUSrcA    = w_srca;
  assign bus.PCWrite    = w_pcw;
  assign bus.RegWrite   = w_rw;
  assign bus.MemWrite   = w_mw;
  assign bus.ResultSrc  = w_res;
  assign bus.ALUSrcB    = w_srcb;
  assign bus.ImmSrc     = w_imm;
  assign bus.RegSrc     = w_regsrc;
  assign bus.FlagW      = w_flagw;
  assign bus.ALUControl = ALU_CTRL_W'(w_alu);
  assign bus.NoWrite    = w_nowr;
  assign bus.Link       = w_link;
  assign bus.State      = r_state;

endmodule

// File: tb/tb_multicycle_decoder.sv
// Scoreboard bench for multicycle_decoder: per-cycle expectations queued by the driver.
// Latency: expectations are compared on the falling edge of the cycle they describe.
// Backpressure: MemReady is driven per cycle from the stimulus rows.
module tb_multicycle_decoder;

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXECR  = 4'd6;
  localparam logic [3:0] EXECI  = 4'd7;
  localparam logic [3:0] ALUWB  = 4'd8;
  localparam logic [3:0] BRANCH = 4'd9;
  localparam logic [3:0] MULEX  = 4'd10;

  typedef struct {
    string      tag;
    logic [3:0] st;
    logic [3:0] strb;   // {IRWrite, PCWrite, RegWrite, MemWrite}
    logic [1:0] flagw;
    logic [2:0] aluc;
    logic [1:0] res;
    logic [1:0] srcb;
    logic       adr;
    logic       nowr;
    logic       link;
  } exp_t;

  logic clk;
  logic reset;

  int   n_checks;
  int   n_errors;
  exp_t sb_q[$];
  exp_t mon_e;

  logic [1:0] cur_op;
  logic [5:0] cur_funct;
  logic [3:0] cur_rd;
  logic       cur_cex;

  multicycle_decoder_if #(.ALU_CTRL_W(3)) bus ();

  multicycle_decoder #(
    .ALU_CTRL_W (3),
    .MEM_WAIT_EN(1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Monitor: pop one expectation per cycle and compare on the falling edge
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      check_val({mon_e.tag, ".state"}, 32'(bus.State), 32'(mon_e.st));
      check_val({mon_e.tag, ".strb"},
                32'({bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite}), 32'(mon_e.strb));
      check_val({mon_e.tag, ".flagw"}, 32'(bus.FlagW), 32'(mon_e.flagw));
      check_val({mon_e.tag, ".aluc"}, 32'(bus.ALUControl), 32'(mon_e.aluc));
      check_val({mon_e.tag, ".res"}, 32'(bus.ResultSrc), 32'(mon_e.res));
      check_val({mon_e.tag, ".srcb"}, 32'(bus.ALUSrcB), 32'(mon_e.srcb));
      check_val({mon_e.tag, ".adr"}, 32'(bus.AdrSrc), 32'(mon_e.adr));
      check_val({mon_e.tag, ".nowr"}, 32'(bus.NoWrite), 32'(mon_e.nowr));
      check_val({mon_e.tag, ".link"}, 32'(bus.Link), 32'(mon_e.link));
    end
  end

  task automatic instr(input logic [1:0] op, input logic [5:0] funct,
                       input logic [3:0] rd, input logic cex);
    cur_op    = op;
    cur_funct = funct;
    cur_rd    = rd;
    cur_cex   = cex;
  endtask

  // One clock of stimulus plus the outputs expected during that clock
  task automatic cyc(input string tag, input logic mr, input logic [3:0] st,
                     input logic [3:0] strb, input logic [1:0] flagw, input logic [2:0] aluc,
                     input logic [1:0] res, input logic [1:0] srcb, input logic adr,
                     input logic nowr, input logic link);
    exp_t e;
    @(posedge clk);
    #1;
    bus.Op       = cur_op;
    bus.Funct    = cur_funct;
    bus.Rd       = cur_rd;
    bus.CondEx   = cur_cex;
    bus.MemReady = mr;
    e.tag   = tag;
    e.st    = st;
    e.strb  = strb;
    e.flagw = flagw;
    e.aluc  = aluc;
    e.res   = res;
    e.srcb  = srcb;
    e.adr   = adr;
    e.nowr  = nowr;
    e.link  = link;
    sb_q.push_back(e);
  endtask

  task automatic fetch_dec(input string tag, input logic nowr);
    cyc({tag, ".F"}, 1'b1, FETCH,  4'b1100, 2'b00, 3'd0, 2'b10, 2'b10, 1'b0, nowr, 1'b0);
    cyc({tag, ".D"}, 1'b1, DECODE, 4'b0000, 2'b00, 3'd0, 2'b10, 2'b10, 1'b0, nowr, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    check_val("drain", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    instr(2'b00, 6'b000000, 4'd0, 1'b1);
    bus.Op       = 2'b00;
    bus.Funct    = 6'b000000;
    bus.Rd       = 4'd0;
    bus.CondEx   = 1'b1;
    bus.MemReady = 1'b1;
    reset        = 1'b0;

    // Held in reset with MemReady high: FETCH, but no strobes
    #12;
    check_val("rst.state", 32'(bus.State), 32'(FETCH));
    check_val("rst.irw", 32'(bus.IRWrite), 32'd0);
    check_val("rst.pcw", 32'(bus.PCWrite), 32'd0);
    check_val("rst.rw", 32'(bus.RegWrite), 32'd0);
    check_val("rst.mw", 32'(bus.MemWrite), 32'd0);
    bus.MemReady = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_val("rel.state", 32'(bus.State), 32'(FETCH));

    // ADD R1,R2,#5
    instr(2'b00, 6'b101000, 4'd1, 1'b1);
    fetch_dec("add", 1'b0);
    cyc("add.EI", 1'b1, EXECI, 4'b0000, 2'b00, 3'd0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
    cyc("add.WB", 1'b1, ALUWB, 4'b0010, 2'b00, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    // LDR with three wait cycles in MEMRD
    instr(2'b01, 6'b011001, 4'd3, 1'b1);
    fetch_dec("ldr", 1'b0);
    cyc("ldr.MA",  1'b1, MEMADR, 4'b0000, 2'b00, 3'd0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
    cyc("ldr.MR0", 1'b0, MEMRD,  4'b0000, 2'b00, 3'd0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    cyc("ldr.MR1", 1'b0, MEMRD,  4'b0000, 2'b00, 3'd0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    cyc("ldr.MR2", 1'b0, MEMRD,  4'b0000, 2'b00, 3'd0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    cyc("ldr.MR3", 1'b1, MEMRD,  4'b0000, 2'b00, 3'd0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    cyc("ldr.WB",  1'b1, MEMWB,  4'b0010, 2'b00, 3'd0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);

    // STR with negative offset, one fetch stall and one write stall
    instr(2'b01, 6'b010000, 4'd4, 1'b1);
    cyc("str.Fw", 1'b0, FETCH, 4'b0000, 2'b00, 3'd0, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0);
    fetch_dec("str", 1'b0);
    cyc("str.MA",  1'b1, MEMADR, 4'b0000, 2'b00, 3'd1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
    cyc("str.MW0", 1'b0, MEMWR,  4'b0000, 2'b00, 3'd0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    cyc("str.MW1", 1'b1, MEMWR,  4'b0001, 2'b00, 3'd0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);

    // CMPS: flags written, result suppressed
    instr(2'b00, 6'b010101, 4'd0, 1'b1);
    fetch_dec("cmp", 1'b1);
    cyc("cmp.ER", 1'b1, EXECR, 4'b0000, 2'b11, 3'd1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    cyc("cmp.WB", 1'b1, ALUWB, 4'b0000, 2'b00, 3'd0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);

    // SUBS into R15: write-back also loads PC
    instr(2'b00, 6'b000101, 4'd15, 1'b1);
    fetch_dec("subpc", 1'b0);
    cyc("subpc.ER", 1'b1, EXECR, 4'b0000, 2'b11, 3'd1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    cyc("subpc.WB", 1'b1, ALUWB, 4'b0110, 2'b00, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    // ORRS with condition failed: no flags, no write
    instr(2'b00, 6'b011001, 4'd2, 1'b0);
    fetch_dec("orr", 1'b0);
    cyc("orr.ER", 1'b1, EXECR, 4'b0000, 2'b00, 3'd3, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    cyc("orr.WB", 1'b1, ALUWB, 4'b0000, 2'b00, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    // MOVS immediate: only N/Z flags
    instr(2'b00, 6'b111011, 4'd5, 1'b1);
    fetch_dec("mov", 1'b0);
    cyc("mov.EI", 1'b1, EXECI, 4'b0000, 2'b10, 3'd6, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
    cyc("mov.WB", 1'b1, ALUWB, 4'b0010, 2'b00, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    // EOR register
    instr(2'b00, 6'b000010, 4'd6, 1'b1);
    fetch_dec("eor", 1'b0);
    cyc("eor.ER", 1'b1, EXECR, 4'b0000, 2'b00, 3'd7, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    cyc("eor.WB", 1'b1, ALUWB, 4'b0010, 2'b00, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    // Unlisted command 0011 with S: ALU code 0, N/Z only
    instr(2'b00, 6'b000111, 4'd7, 1'b1);
    fetch_dec("unk", 1'b0);
    cyc("unk.ER", 1'b1, EXECR, 4'b0000, 2'b10, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    cyc("unk.WB", 1'b1, ALUWB, 4'b0010, 2'b00, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    // MUL encoding with S
    instr(2'b00, 6'b000001, 4'd8, 1'b1);
    fetch_dec("mul", 1'b0);
`ifdef MUL_EN
    cyc("mul.MX", 1'b1, MULEX, 4'b0000, 2'b10, 3'd4, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
`else
    cyc("mul.ER", 1'b1, EXECR, 4'b0000, 2'b10, 3'd2, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
`endif
    cyc("mul.WB", 1'b1, ALUWB, 4'b0010, 2'b00, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    // BL taken and not taken
    instr(2'b10, 6'b010000, 4'd0, 1'b1);
    fetch_dec("bl1", 1'b0);
    cyc("bl1.BR", 1'b1, BRANCH, 4'b0110, 2'b00, 3'd0, 2'b10, 2'b01, 1'b0, 1'b0, 1'b1);
    instr(2'b10, 6'b010000, 4'd0, 1'b0);
    fetch_dec("bl0", 1'b0);
    cyc("bl0.BR", 1'b1, BRANCH, 4'b0000, 2'b00, 3'd0, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0);

    // Op=11: DECODE straight back to FETCH (checked by the next FETCH row)
    instr(2'b11, 6'b000000, 4'd0, 1'b1);
    fetch_dec("op3", 1'b0);

    // STR parked in MEMWR, then reset arrives asynchronously
    instr(2'b01, 6'b011000, 4'd4, 1'b1);
    fetch_dec("strr", 1'b0);
    cyc("strr.MA",  1'b1, MEMADR, 4'b0000, 2'b00, 3'd0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
    cyc("strr.MW0", 1'b0, MEMWR,  4'b0000, 2'b00, 3'd0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    drain();

    @(posedge clk);
    #1;
    bus.MemReady = 1'b1;
    #1;
    check_val("arst.pre_state", 32'(bus.State), 32'(MEMWR));
    check_val("arst.pre_mw", 32'(bus.MemWrite), 32'd1);
    reset = 1'b0;
    #1;
    check_val("arst.mw", 32'(bus.MemWrite), 32'd0);
    check_val("arst.state", 32'(bus.State), 32'(FETCH));
    check_val("arst.irw", 32'(bus.IRWrite), 32'd0);
    @(posedge clk);
    #1;
    check_val("arst.hold_state", 32'(bus.State), 32'(FETCH));
    check_val("arst.hold_pcw", 32'(bus.PCWrite), 32'd0);
    bus.MemReady = 1'b0;
    reset        = 1'b1;
    #1;
    check_val("arst.rel_state", 32'(bus.State), 32'(FETCH));
    @(posedge clk);
    #1;
    bus.MemReady = 1'b1;
    #1;
    check_val("arst.fetch_irw", 32'(bus.IRWrite), 32'd1);
    check_val("arst.fetch_state", 32'(bus.State), 32'(FETCH));
    @(posedge clk);
    #2;
    check_val("arst.decode", 32'(bus.State), 32'(DECODE));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
